latch_mem_arbiter: RTL and testbench
====================================

// Module: latch_mem_arbiter
// PURPOSE
// - Two-master front end for latch_mem: shares the latch RAM between the TinyQV data port and the APU sample fetcher.
// - Grants one master at a time and steers addr/data/read_n/write_n to latch_mem.
// - Routes latch_mem data_out/data_ready back to the granted master.
// - Forces one idle (11) cycle between transactions so the latch_mem byte-cycle counter restarts cleanly.
// PARAMETERS
// - ADDR_BITS  5  width of RAM byte address (RAM is 2**ADDR_BITS bytes)
// PORTS
// - clk               in   1          single clock; all state on posedge
// - rst               in   1          reset, asynchronous, active-high
// - host_addr         in   ADDR_BITS  TinyQV byte address
// - host_data_in      in   32         TinyQV write data
// - host_write_n      in   2          11 none, 00 8b, 01 16b, 10 32b; held until host_data_ready
// - host_read_n       in   2          same encoding; held until host_data_ready
// - host_data_out     out  32         read data, valid while host_data_ready=1
// - host_data_ready   out  1          transaction complete (read or write)
// - apu_req           in   1          level: APU wants one read
// - apu_addr          in   ADDR_BITS  APU byte address, sampled at grant
// - apu_size_n        in   2          00 8b, 01 16b, 10 32b (11 treated as 00)
// - apu_ack           out  1          one-cycle pulse: apu_data valid
// - apu_data          out  32         registered read data, holds until next ack
// - mem_addr          out  ADDR_BITS  to latch_mem addr_in
// - mem_data_in       out  32         to latch_mem data_in
// - mem_write_n       out  2          to latch_mem data_write_n
// - mem_read_n        out  2          to latch_mem data_read_n
// - mem_data_out      in   32         from latch_mem data_out
// - mem_data_ready    in   1          from latch_mem data_ready
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, last_apu=0, apu_ack=0, apu_data=0.
//   mem_write_n=mem_read_n=11; host_data_ready=0. Mid-transaction reset aborts silently, no ack/ready.
// - States:
//   - IDLE: mem_*_n=11. Arbitration evaluated every IDLE cycle.
//   - HOST: mem_* = host_* combinationally.
//     host_data_out=mem_data_out; host_data_ready=mem_data_ready.
//   - APU: mem_addr = latched apu_addr; mem_read_n = latched size; mem_write_n=11; mem_data_in=0.
// - Host pending = (host_read_n & host_write_n) != 11. Arbitration in IDLE:
//   - only one pending -> grant it.
//   - both pending -> grant HOST if last_apu=1, else APU (round-robin).
//   - last_apu <= 1 on APU grant, 0 on HOST grant.
// - Completion:
//   - HOST: mem_data_ready=1 -> IDLE on that edge.
//   - APU: mem_data_ready=1 -> IDLE, apu_data<=mem_data_out, apu_ack<=1 for exactly one cycle.
// - Host abort: host request returns to 11 while in HOST before ready -> IDLE, no ready.
//   APU cannot abort once granted.
// - Latency, from request visible in IDLE (cycle T):
//   - 8b: ready at T+2.
//   - 16b: ready at T+3.
//   - 32b: ready at T+5.
//   - apu_ack follows the ready edge by one cycle.
//   - Minimum issue spacing: one IDLE cycle after each completion.
// - apu_req still high in the apu_ack cycle (which is IDLE) counts as a new request.
// - host_data_ready=0 outside HOST. host_data_out undefined outside HOST, drive mem_data_out.
// - Back-to-back contention: neither master waits more than one foreign transaction.
// TESTING
// - Reset: rst pulse mid-APU 32b read -> mem_*_n=11 immediately, apu_ack stays 0, state IDLE.
// - Host 8b write 0xA5 @3, then 8b read @3:
//   - write ready at T+2.
//   - read ready 2 cycles after its IDLE; host_data_out[7:0]=0xA5.
// - Host 32b write 0x11223344 @4; APU 32b read @4:
//   - apu_ack 6 cycles after grant; apu_data=0x11223344.
// - Simultaneous pending, last_apu=0:
//   - APU granted first, host second.
//   - Repeat with both held: grants alternate APU,HOST,APU.
// - apu_req held high across ack -> second APU read issued after exactly one IDLE cycle.
// - Host 16b read @31 with host abort after 1 cycle -> IDLE, no host_data_ready; next APU 8b read completes normally.

Source files
------------

// File: rtl/latch_mem_arbiter.sv
// latch_mem_arbiter
// Two-master front end for the latch RAM. The TinyQV data port (host) and the
// APU sample fetcher share one latch_mem instance. One master owns the RAM
// port at a time. Every transaction is followed by at least one IDLE cycle with
// both strobes at 11, so the byte-cycle counter inside latch_mem restarts from
// zero before the next transaction.

module latch_mem_arbiter #(
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   // TinyQV data port
   input  logic [ADDR_BITS-1:0] i_host_addr,
   input  logic [31:0]          i_host_data_in,
   input  logic [1:0]           i_host_write_n,
   input  logic [1:0]           i_host_read_n,
   output logic [31:0]          o_host_data_out,
   output logic                 o_host_data_ready,
   // APU sample fetcher
   input  logic                 i_apu_req,
   input  logic [ADDR_BITS-1:0] i_apu_addr,
   input  logic [1:0]           i_apu_size_n,
   output logic                 o_apu_ack,
   output logic [31:0]          o_apu_data,
   // latch_mem side
   output logic [ADDR_BITS-1:0] o_mem_addr,
   output logic [31:0]          o_mem_data_in,
   output logic [1:0]           o_mem_write_n,
   output logic [1:0]           o_mem_read_n,
   input  logic [31:0]          i_mem_data_out,
   input  logic                 i_mem_data_ready
);

   // Ownership of the RAM port
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOST = 2'd1;
   localparam logic [1:0] ST_APU  = 2'd2;

   logic [1:0]           r_state;
   logic                 r_last_apu;
   logic [ADDR_BITS-1:0] r_apu_addr;
   logic [1:0]           r_apu_size_n;
   logic                 r_apu_ack;
   logic [31:0]          r_apu_data;

   logic                 w_host_pending;
   logic                 w_grant_host;
   logic                 w_grant_apu;
   logic                 w_apu_done;
   logic [1:0]           w_apu_size_eff;
   logic [1:0]           w_next_state;

   // The host holds its strobe until ready, so any non-11 strobe is a live request
   assign w_host_pending = ((i_host_read_n & i_host_write_n) != 2'b11);

   // Round-robin arbitration; when both ask, whoever did not go last wins
   assign w_grant_host = (r_state == ST_IDLE) && w_host_pending &&
                         (!i_apu_req || r_last_apu);
   assign w_grant_apu  = (r_state == ST_IDLE) && i_apu_req &&
                         (!w_host_pending || !r_last_apu);

   // The 11 size code has no meaning for a read request, fall back to a byte
   assign w_apu_size_eff = (i_apu_size_n == 2'b11) ? 2'b00 : i_apu_size_n;

   // APU transactions cannot be aborted, so ready alone ends them
   assign w_apu_done = (r_state == ST_APU) && i_mem_data_ready;

   // Next owner of the RAM port; every exit goes through IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_apu) begin
               w_next_state = ST_APU;
            end else if (w_grant_host) begin
               w_next_state = ST_HOST;
            end
         end
         ST_HOST: begin
            if (i_mem_data_ready || !w_host_pending) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_APU: begin
            if (i_mem_data_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register plus the round-robin memory of who was granted last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last_apu <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_grant_apu) begin
            r_last_apu <= 1'b1;
         end else if (w_grant_host) begin
            r_last_apu <= 1'b0;
         end
      end
   end

   // APU address and size are captured at grant so the APU may move on afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_apu_addr   <= '0;
         r_apu_size_n <= 2'b00;
      end else if (w_grant_apu) begin
         r_apu_addr   <= i_apu_addr;
         r_apu_size_n <= w_apu_size_eff;
      end
   end

   // One-cycle ack with the read word held until the next completed APU read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_apu_ack  <= 1'b0;
         r_apu_data <= '0;
      end else begin
         r_apu_ack <= w_apu_done;
         if (w_apu_done) begin
            r_apu_data <= i_mem_data_out;
         end
      end
   end

   // Steer the owner onto the RAM port; IDLE parks both strobes at 11
   always_comb begin
      o_mem_addr        = '0;
      o_mem_data_in     = '0;
      o_mem_write_n     = 2'b11;
      o_mem_read_n      = 2'b11;
      o_host_data_ready = 1'b0;
      case (r_state)
         ST_HOST: begin
            o_mem_addr        = i_host_addr;
            o_mem_data_in     = i_host_data_in;
            o_mem_write_n     = i_host_write_n;
            o_mem_read_n      = i_host_read_n;
            o_host_data_ready = i_mem_data_ready;
         end
         ST_APU: begin
            o_mem_addr   = r_apu_addr;
            o_mem_read_n = r_apu_size_n;
         end
         default: begin
            o_mem_write_n = 2'b11;
         end
      endcase
   end

   assign o_host_data_out = i_mem_data_out;
   assign o_apu_ack       = r_apu_ack;
   assign o_apu_data      = r_apu_data;

endmodule

// File: tb/tb_latch_mem_arbiter.sv
// tb_latch_mem_arbiter
// Directed bench for latch_mem_arbiter with a byte-serial RAM model standing in
// for latch_mem and an ownership-level model of the arbiter that is compared
// against the DUT on every falling edge.

module tb_latch_mem_arbiter;

   localparam int AW   = 5;
   localparam int NONE = 0;
   localparam int HOST = 1;
   localparam int APU  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic [AW-1:0] host_addr    = '0;
   logic [31:0]   host_data_in = '0;
   logic [1:0]    host_write_n = 2'b11;
   logic [1:0]    host_read_n  = 2'b11;
   logic [31:0]   o_host_data_out;
   logic          o_host_data_ready;
   logic          apu_req      = 1'b0;
   logic [AW-1:0] apu_addr     = '0;
   logic [1:0]    apu_size_n   = 2'b00;
   logic          o_apu_ack;
   logic [31:0]   o_apu_data;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [1:0]    mem_wr_n;
   logic [1:0]    mem_rd_n;
   logic [31:0]   mem_dout;
   logic          mem_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   latch_mem_arbiter #(.ADDR_BITS(AW)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_host_addr       (host_addr),
      .i_host_data_in    (host_data_in),
      .i_host_write_n    (host_write_n),
      .i_host_read_n     (host_read_n),
      .o_host_data_out   (o_host_data_out),
      .o_host_data_ready (o_host_data_ready),
      .i_apu_req         (apu_req),
      .i_apu_addr        (apu_addr),
      .i_apu_size_n      (apu_size_n),
      .o_apu_ack         (o_apu_ack),
      .o_apu_data        (o_apu_data),
      .o_mem_addr        (mem_addr),
      .o_mem_data_in     (mem_din),
      .o_mem_write_n     (mem_wr_n),
      .o_mem_read_n      (mem_rd_n),
      .i_mem_data_out    (mem_dout),
      .i_mem_data_ready  (mem_rdy)
   );

   always #5 clk = ~clk;

   // RAM stand-in: one byte per cycle, ready once the last byte is handled,
   // counter restarts whenever both strobes return to 11
   logic [7:0]  ram [0:31];
   int          mem_cnt;
   int          mem_nb;
   logic        mem_active;
   logic        mem_is_wr;
   logic [31:0] mem_rd_word;

   always_comb begin
      mem_is_wr   = (mem_wr_n != 2'b11);
      mem_active  = mem_is_wr || (mem_rd_n != 2'b11);
      mem_nb      = 1 << (mem_is_wr ? mem_wr_n : mem_rd_n);
      mem_rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < mem_nb) begin
            mem_rd_word[8*k +: 8] = ram[mem_addr + 5'(k)];
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_cnt  <= 0;
         mem_rdy  <= 1'b0;
         mem_dout <= '0;
      end else if (mem_active) begin
         if (mem_cnt == mem_nb - 1) begin
            if (!mem_rdy) begin
               if (mem_is_wr) begin
                  for (int k = 0; k < 4; k++) begin
                     if (k < mem_nb) begin
                        ram[mem_addr + 5'(k)] <= mem_din[8*k +: 8];
                     end
                  end
               end else begin
                  mem_dout <= mem_rd_word;
               end
            end
            mem_rdy <= 1'b1;
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
         mem_rdy <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Ownership model: who holds the RAM, who went last, what the APU latched
   int            m_owner    = NONE;
   int            m_last     = HOST;
   logic [AW-1:0] m_apu_addr = '0;
   logic [1:0]    m_apu_sz   = 2'b00;
   logic          m_ack      = 1'b0;
   logic [31:0]   m_apu_data = '0;

   initial begin : compare_proc
      logic host_wants;
      int   winner;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_owner    = NONE;
            m_last     = HOST;
            m_ack      = 1'b0;
            m_apu_data = '0;
         end
         checkOutput("bus_read_n", 32'(mem_rd_n),
                     32'(m_owner == HOST ? host_read_n : (m_owner == APU ? m_apu_sz : 2'b11)));
         checkOutput("bus_write_n", 32'(mem_wr_n),
                     32'(m_owner == HOST ? host_write_n : 2'b11));
         if (m_owner != NONE) begin
            checkOutput("bus_addr", 32'(mem_addr),
                        32'(m_owner == HOST ? host_addr : m_apu_addr));
            checkOutput("bus_data_in", mem_din, (m_owner == HOST) ? host_data_in : 32'd0);
         end
         checkOutput("host_ready", 32'(o_host_data_ready), 32'(m_owner == HOST && mem_rdy));
         if (m_owner == HOST && mem_rdy) begin
            checkOutput("host_data_out", o_host_data_out, mem_dout);
         end
         checkOutput("apu_ack", 32'(o_apu_ack), 32'(m_ack));
         checkOutput("apu_data", o_apu_data, m_apu_data);
         if (!rst) begin
            m_ack      = 1'b0;
            host_wants = ((host_read_n & host_write_n) != 2'b11);
            if (m_owner == NONE) begin
               winner = NONE;
               if (host_wants && apu_req) begin
                  winner = (m_last == APU) ? HOST : APU;
               end else if (host_wants) begin
                  winner = HOST;
               end else if (apu_req) begin
                  winner = APU;
               end
               if (winner == APU) begin
                  m_apu_addr = apu_addr;
                  m_apu_sz   = (apu_size_n == 2'b11) ? 2'b00 : apu_size_n;
               end
               if (winner != NONE) begin
                  m_last = winner;
               end
               m_owner = winner;
            end else if (mem_rdy) begin
               if (m_owner == APU) begin
                  m_ack      = 1'b1;
                  m_apu_data = mem_dout;
               end
               m_owner = NONE;
            end else if (m_owner == HOST && !host_wants) begin
               m_owner = NONE;
            end
         end
      end
   end

   // One host transaction; latency counted in cycles from the request cycle
   task automatic applyStimulusHost(input logic [AW-1:0] a, input logic [31:0] d,
                                    input bit wr, input logic [1:0] sz,
                                    output int lat, output logic [31:0] rdata);
      @(posedge clk); #1;
      host_addr    = a;
      host_data_in = d;
      if (wr) begin
         host_write_n = sz;
         host_read_n  = 2'b11;
      end else begin
         host_read_n  = sz;
         host_write_n = 2'b11;
      end
      lat = 0;
      @(negedge clk);
      while (!o_host_data_ready && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      rdata = o_host_data_out;
      checkOutput("host_ready_seen", 32'(o_host_data_ready), 32'd1);
      @(posedge clk); #1;
      host_write_n = 2'b11;
      host_read_n  = 2'b11;
   endtask

   // One APU read; request dropped as soon as the RAM port shows it was granted
   task automatic applyStimulusApu(input logic [AW-1:0] a, input logic [1:0] sz,
                                   output int lat, output logic [31:0] data);
      logic [1:0] eff;
      bit         seen;
      eff = (sz == 2'b11) ? 2'b00 : sz;
      @(posedge clk); #1;
      apu_req    = 1'b1;
      apu_addr   = a;
      apu_size_n = sz;
      lat  = 0;
      seen = 1'b0;
      @(negedge clk);
      while (!seen && lat < 40) begin
         if (apu_req && mem_rd_n == eff && mem_wr_n == 2'b11 && mem_addr == a) begin
            apu_req = 1'b0;
         end
         if (o_apu_ack) begin
            seen = 1'b1;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      apu_req = 1'b0;
      data = o_apu_data;
      checkOutput("apu_ack_seen", 32'(o_apu_ack), 32'd1);
   endtask

   task automatic waitIdle();
      int quiet;
      int c;
      quiet = 0;
      c     = 0;
      while (quiet < 3 && c < 60) begin
         @(negedge clk);
         c++;
         if (mem_rd_n == 2'b11 && mem_wr_n == 2'b11 && !o_apu_ack) quiet++;
         else quiet = 0;
      end
      checkOutput("idle_reached", 32'(quiet), 32'd3);
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int          lat_h;
      int          lat_a;
      int          acks;
      int          rdys;
      int          grants[$];
      logic [31:0] rd_h;
      logic [31:0] rd_a;
      logic [5:0]  act_bits;
      logic [5:0]  ack_bits;
      bit          prev_act;
      bit          act;

      // Reset values
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_read_n", 32'(mem_rd_n), 32'd3);
      checkOutput("reset_write_n", 32'(mem_wr_n), 32'd3);
      checkOutput("reset_apu_ack", 32'(o_apu_ack), 32'd0);
      checkOutput("reset_apu_data", o_apu_data, 32'd0);
      checkOutput("reset_host_ready", 32'(o_host_data_ready), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      waitIdle();

      // Host byte write then byte read at address 3
      $display("[TB] host 8b write/read");
      applyStimulusHost(5'd3, 32'h0000_00A5, 1'b1, 2'b00, lat_h, rd_h);
      checkOutput("host_w8_latency", 32'(lat_h), 32'd2);
      applyStimulusHost(5'd3, 32'h0, 1'b0, 2'b00, lat_h, rd_h);
      checkOutput("host_r8_latency", 32'(lat_h), 32'd2);
      checkOutput("host_r8_data", 32'(rd_h[7:0]), 32'h0000_00A5);
      waitIdle();

      // Host word write, APU word read of the same location
      $display("[TB] host 32b write, apu 32b read");
      applyStimulusHost(5'd4, 32'h1122_3344, 1'b1, 2'b10, lat_h, rd_h);
      checkOutput("host_w32_latency", 32'(lat_h), 32'd5);
      applyStimulusApu(5'd4, 2'b10, lat_a, rd_a);
      checkOutput("apu_r32_latency", 32'(lat_a), 32'd6);
      checkOutput("apu_r32_data", rd_a, 32'h1122_3344);
      waitIdle();

      // Reset in the middle of an APU word read
      $display("[TB] reset during apu read");
      @(posedge clk); #1;
      apu_req    = 1'b1;
      apu_addr   = 5'd8;
      apu_size_n = 2'b10;
      @(posedge clk); #1;
      apu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_read_n", 32'(mem_rd_n), 32'd3);
      checkOutput("midrst_write_n", 32'(mem_wr_n), 32'd3);
      @(posedge clk); #1;
      rst  = 1'b0;
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (o_apu_ack) acks++;
      end
      checkOutput("midrst_no_ack", 32'(acks), 32'd0);

      // Both request together with last_apu clear: APU first, host second
      $display("[TB] simultaneous requests");
      fork
         applyStimulusHost(5'd3, 32'h0, 1'b0, 2'b00, lat_h, rd_h);
         applyStimulusApu(5'd5, 2'b00, lat_a, rd_a);
      join
      checkOutput("simul_apu_latency", 32'(lat_a), 32'd3);
      checkOutput("simul_apu_data", rd_a, 32'h0000_0033);
      checkOutput("simul_host_latency", 32'(lat_h), 32'd5);
      checkOutput("simul_host_data", 32'(rd_h[7:0]), 32'h0000_00A5);
      waitIdle();

      // Both held: grants must alternate APU, HOST, APU
      $display("[TB] alternating grants");
      grants.delete();
      prev_act = 1'b0;
      fork
         begin
            @(posedge clk); #1;
            apu_req    = 1'b1;
            apu_addr   = 5'd6;
            apu_size_n = 2'b00;
         end
         applyStimulusHost(5'd3, 32'h0, 1'b0, 2'b00, lat_h, rd_h);
         begin
            for (int c = 0; c < 20 && grants.size() < 3; c++) begin
               @(negedge clk);
               act = (mem_rd_n != 2'b11) || (mem_wr_n != 2'b11);
               if (act && !prev_act) grants.push_back((mem_addr == 5'd6) ? APU : HOST);
               prev_act = act;
            end
         end
      join
      apu_req = 1'b0;
      checkOutput("alt_grant_count", 32'(grants.size()), 32'd3);
      if (grants.size() == 3) begin
         checkOutput("alt_grant0", 32'(grants[0]), 32'(APU));
         checkOutput("alt_grant1", 32'(grants[1]), 32'(HOST));
         checkOutput("alt_grant2", 32'(grants[2]), 32'(APU));
      end
      checkOutput("alt_host_latency", 32'(lat_h), 32'd5);
      waitIdle();

      // APU request held across its ack: re-issue after one IDLE cycle
      $display("[TB] apu request held across ack");
      @(posedge clk); #1;
      apu_req    = 1'b1;
      apu_addr   = 5'd5;
      apu_size_n = 2'b11;
      act_bits   = '0;
      ack_bits   = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         act_bits[c] = (mem_rd_n != 2'b11) || (mem_wr_n != 2'b11);
         ack_bits[c] = o_apu_ack;
         if (c == 4) apu_req = 1'b0;
      end
      checkOutput("held_bus_pattern", 32'(act_bits), 32'(6'b110110));
      checkOutput("held_ack_pattern", 32'(ack_bits), 32'(6'b001000));
      checkOutput("held_apu_data", o_apu_data, 32'h0000_0033);
      waitIdle();

      // Host 16b read aborted after one cycle, then a normal APU byte read
      $display("[TB] host abort");
      rdys = 0;
      @(posedge clk); #1;
      host_addr   = 5'd31;
      host_read_n = 2'b01;
      @(negedge clk);
      if (o_host_data_ready) rdys++;
      @(posedge clk); #1;
      @(negedge clk);
      if (o_host_data_ready) rdys++;
      checkOutput("abort_granted_addr", 32'(mem_addr), 32'd31);
      @(posedge clk); #1;
      host_read_n = 2'b11;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (o_host_data_ready) rdys++;
      end
      checkOutput("abort_no_ready", 32'(rdys), 32'd0);
      applyStimulusApu(5'd3, 2'b00, lat_a, rd_a);
      checkOutput("abort_apu_latency", 32'(lat_a), 32'd3);
      checkOutput("abort_apu_data", rd_a, 32'h0000_00A5);
      waitIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
